// File: rtl/ysyx_24100029_pkg.sv
// Shared definitions for the instruction-queue slice: default geometry and the fetch entry layout.
// Optional branch-prediction payload is enabled with `define INST_QUEUE_PRED_EN.
package ysyx_24100029_pkg;

  localparam int IQ_DEPTH   = 16;
  localparam int IQ_FETCH_W = 4;
  localparam int IQ_ISSUE_W = 4;
  localparam int IQ_ADDR_W  = 32;
  localparam int IQ_INST_W  = 32;

  typedef struct packed {
    logic [IQ_ADDR_W-1:0] pc;
    logic [IQ_INST_W-1:0] inst;
`ifdef INST_QUEUE_PRED_EN
    logic                 pred_taken;
    logic [IQ_ADDR_W-1:0] pred_npc;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_24100029_lead_ones.sv
// Counts consecutive ones starting at bit 0; used to turn per-slot valid/handshake
// vectors into an in-order enqueue or dequeue count.
module ysyx_24100029_lead_ones #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & vec[i];
      if (run) cnt = CW'(i + 1);
    end
  end

endmodule

// File: rtl/ysyx_24100029_inst_queue.sv
// Multi-issue instruction queue between fetch and decode: in-order group enqueue,
// in-order partial dequeue, flush on redirect. Optional feature macro: INST_QUEUE_PRED_EN.
module ysyx_24100029_inst_queue
  import ysyx_24100029_pkg::*;
#(
  parameter int DEPTH      = IQ_DEPTH,
  parameter int FETCH_W    = IQ_FETCH_W,
  parameter int ISSUE_W    = IQ_ISSUE_W,
  parameter int ADDR_WIDTH = IQ_ADDR_W,
  parameter int INST_WIDTH = IQ_INST_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clr,
  input  logic [FETCH_W-1:0]            in_valid,
  output logic                          in_ready,
  input  logic [FETCH_W*ADDR_WIDTH-1:0] in_pc,
  input  logic [FETCH_W*INST_WIDTH-1:0] in_inst,
`ifdef INST_QUEUE_PRED_EN
  input  logic [FETCH_W-1:0]            in_pred_taken,
  input  logic [FETCH_W*ADDR_WIDTH-1:0] in_pred_npc,
  output logic [ISSUE_W-1:0]            out_pred_taken,
  output logic [ISSUE_W*ADDR_WIDTH-1:0] out_pred_npc,
`endif
  output logic [ISSUE_W-1:0]            out_valid,
  input  logic [ISSUE_W-1:0]            out_ready,
  output logic [ISSUE_W*ADDR_WIDTH-1:0] out_pc,
  output logic [ISSUE_W*INST_WIDTH-1:0] out_inst,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = $clog2(FETCH_W + 1);
  localparam int DW = $clog2(ISSUE_W + 1);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
`ifdef INST_QUEUE_PRED_EN
  logic                  pt_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] npc_mem  [DEPTH];
`endif

  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      cnt;
  logic [EW-1:0]      enq_n, enq_eff;
  logic [DW-1:0]      deq_n;
  logic [ISSUE_W-1:0] deq_hs;

  // Acceptance depends on occupancy alone so decode back-pressure never reaches fetch combinationally.
  assign in_ready = (cnt <= CW'(DEPTH - FETCH_W));
  assign enq_eff  = in_ready ? enq_n : '0;
  assign deq_hs   = out_valid & out_ready;
  assign count    = cnt;

  ysyx_24100029_lead_ones #(.W(FETCH_W), .CW(EW)) u_enq_cnt (
    .vec (in_valid),
    .cnt (enq_n)
  );

  ysyx_24100029_lead_ones #(.W(ISSUE_W), .CW(DW)) u_deq_cnt (
    .vec (deq_hs),
    .cnt (deq_n)
  );

  // Issue window: slot g always shows entry head+g, valid only while occupied.
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_out
    logic [PW-1:0] ridx;
    assign ridx          = head + PW'(g);
    assign out_valid[g]  = (cnt > CW'(g));
    assign out_pc[g*ADDR_WIDTH +: ADDR_WIDTH]   = pc_mem[ridx];
    assign out_inst[g*INST_WIDTH +: INST_WIDTH] = inst_mem[ridx];
`ifdef INST_QUEUE_PRED_EN
    assign out_pred_taken[g]                    = pt_mem[ridx];
    assign out_pred_npc[g*ADDR_WIDTH +: ADDR_WIDTH] = npc_mem[ridx];
`endif
  end

  // Pointer / occupancy state
  always_ff @(posedge clock) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(deq_n);
      tail <= tail + PW'(enq_eff);
      cnt  <= cnt + CW'(enq_eff) - CW'(deq_n);
    end
  end

  // Storage write; a flush leaves stale contents behind since they are unreachable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        pc_mem[d]   <= '0;
        inst_mem[d] <= '0;
`ifdef INST_QUEUE_PRED_EN
        pt_mem[d]   <= 1'b0;
        npc_mem[d]  <= '0;
`endif
      end
    end else if (!clr) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (EW'(i) < enq_eff) begin
          pc_mem[tail + PW'(i)]   <= in_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
          inst_mem[tail + PW'(i)] <= in_inst[i*INST_WIDTH +: INST_WIDTH];
`ifdef INST_QUEUE_PRED_EN
          pt_mem[tail + PW'(i)]   <= in_pred_taken[i];
          npc_mem[tail + PW'(i)]  <= in_pred_npc[i*ADDR_WIDTH +: ADDR_WIDTH];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_inst_queue.sv
// Self-checking bench for ysyx_24100029_inst_queue: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_ysyx_24100029_inst_queue;
  import ysyx_24100029_pkg::*;

  localparam int DEPTH = 16;
  localparam int FW    = 4;
  localparam int IW    = 4;
  localparam int AW    = 32;
  localparam int NW    = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            clr   = 1'b0;
  logic [FW-1:0]   in_valid = '0;
  logic            in_ready;
  logic [FW*AW-1:0] in_pc   = '0;
  logic [FW*NW-1:0] in_inst = '0;
`ifdef INST_QUEUE_PRED_EN
  logic [FW-1:0]    in_pred_taken = '0;
  logic [FW*AW-1:0] in_pred_npc   = '0;
  logic [IW-1:0]    out_pred_taken;
  logic [IW*AW-1:0] out_pred_npc;
`endif
  logic [IW-1:0]    out_valid;
  logic [IW-1:0]    out_ready = '0;
  logic [IW*AW-1:0] out_pc;
  logic [IW*NW-1:0] out_inst;
  logic [$clog2(DEPTH):0] count;

  ysyx_24100029_inst_queue #(
    .DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW), .ADDR_WIDTH(AW), .INST_WIDTH(NW)
  ) dut (
    .clock(clock), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
`ifdef INST_QUEUE_PRED_EN
    .in_pred_taken(in_pred_taken), .in_pred_npc(in_pred_npc),
    .out_pred_taken(out_pred_taken), .out_pred_npc(out_pred_npc),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .count(count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  fetch_entry_t model_q[$];
  logic [31:0] next_pc = 32'h8000_0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lead(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && n == i) n = i + 1;
    end
    return n;
  endfunction

  // Drives one cycle of inputs, checks outputs against the model, then advances the model.
  task automatic step(input logic [3:0] v, input logic [3:0] r, input logic c);
    int sz, e, d;
    logic rdy;
    logic [3:0] vexp;
    fetch_entry_t ent;
    in_valid  = v;
    out_ready = r;
    clr       = c;
    for (int i = 0; i < FW; i++) begin
      in_pc[i*AW +: AW]   = next_pc + 32'(4 * i);
      in_inst[i*NW +: NW] = $urandom;
`ifdef INST_QUEUE_PRED_EN
      in_pred_taken[i]       = 1'($urandom_range(0, 1));
      in_pred_npc[i*AW +: AW] = $urandom;
`endif
    end
    @(negedge clock);
    sz   = model_q.size();
    rdy  = ((DEPTH - sz) >= FW);
    vexp = '0;
    for (int i = 0; i < IW; i++) vexp[i] = (sz > i);
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(vexp));
    for (int i = 0; i < IW; i++) begin
      if (i < sz) begin
        chk($sformatf("out_pc[%0d]", i), 64'(out_pc[i*AW +: AW]), 64'(model_q[i].pc));
        chk($sformatf("out_inst[%0d]", i), 64'(out_inst[i*NW +: NW]), 64'(model_q[i].inst));
`ifdef INST_QUEUE_PRED_EN
        chk($sformatf("out_pred_taken[%0d]", i), 64'(out_pred_taken[i]), 64'(model_q[i].pred_taken));
        chk($sformatf("out_pred_npc[%0d]", i), 64'(out_pred_npc[i*AW +: AW]), 64'(model_q[i].pred_npc));
`endif
      end
    end
    if (!reset || c) begin
      model_q.delete();
    end else begin
      d = lead(vexp & r);
      for (int k = 0; k < d; k++) void'(model_q.pop_front());
      if (rdy) begin
        e = lead(v);
        for (int k = 0; k < e; k++) begin
          ent = '0;
          ent.pc   = in_pc[k*AW +: AW];
          ent.inst = in_inst[k*NW +: NW];
`ifdef INST_QUEUE_PRED_EN
          ent.pred_taken = in_pred_taken[k];
          ent.pred_npc   = in_pred_npc[k*AW +: AW];
`endif
          model_q.push_back(ent);
        end
        next_pc = next_pc + 32'(4 * e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] rv, rr;
    logic       rc;

    // Reset values
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc[63:0]), 64'd0);
    chk("rst_out_inst", 64'(out_inst[63:0]), 64'd0);
    reset = 1'b1;

    // Fill with no decode ready
    for (int k = 0; k < 4; k++) step(4'b1111, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_pc0", 64'(out_pc[31:0]), 64'h8000_0000);

    // Full: enqueue refused, dequeue 4
    step(4'b1111, 4'b1111, 1'b0);
    chk("full_deq_count", 64'(count), 64'd12);

    // Gapped valid / gapped ready
    step(4'b1011, 4'b0000, 1'b0);
    chk("gap_enq_count", 64'(count), 64'd14);
    step(4'b0000, 4'b1101, 1'b0);
    chk("gap_deq_count", 64'(count), 64'd13);

    // Random traffic with wrap-around and occasional flush
    for (int k = 0; k < 150; k++) begin
      rv = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rc = ($urandom_range(0, 59) == 0);
      step(rv, rr, rc);
    end

    // Flush at occupancy 9 with a full group offered
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    chk("pre_clr_count", 64'(count), 64'd9);
    step(4'b1111, 4'b1111, 1'b1);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of traffic
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0011, 1'b0);
    reset = 1'b0;
    step(4'b1111, 4'b1111, 1'b0);
    reset = 1'b1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
    step(4'b0111, 4'b0000, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
